// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Latency: 4 cycles minimum (sample, grant pulse, SETUP, ACCESS with pready, response).
// Backpressure: no queueing; requests are sampled only while idle, and losers must hold req_valid.
//
// Ports:
//   pclock, presetn            clock, asynchronous active-low reset
//   req_valid/write/addr/wdata per-requester request (slice i belongs to requester i)
//   req_ready                  one-cycle accept pulse to the granted requester
//   rsp_valid/rdata/err        one-cycle completion to the owning requester
//   paddr/pwdata/pwrite/psel/penable, prdata/pready/pslverr   APB master side
module apb_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    pclock,
    input  logic                    presetn,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic                    pwrite,
    output logic                    psel,
    output logic                    penable,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Abort is decided on the edge that ends the TIMEOUT-th waiting ACCESS
    // cycle, so the registered bus drops on the cycle right after it.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic                    grant_pend_q, grant_pend_d;
    logic                    armed_q, armed_d;
    logic                    owner_q, owner_d;
    logic                    last_grant_q, last_grant_d;
    logic [7:0]              wait_cnt_q, wait_cnt_d;
    logic                    pick;

    logic [1:0]              req_ready_d;
    logic [1:0]              rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_d;
    logic                    rsp_err_d;
    logic [ADDR_WIDTH-1:0]   paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_d;
    logic                    pwrite_d;
    logic                    psel_d;
    logic                    penable_d;

    always_comb begin
        state_d      = state_q;
        grant_pend_d = grant_pend_q;
        armed_d      = 1'b1;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata;
        rsp_err_d    = rsp_err;
        paddr_d      = paddr;
        pwdata_d     = pwdata;
        pwrite_d     = pwrite;
        psel_d       = psel;
        penable_d    = penable;

        // Contention goes to whoever was not granted last; a lone requester wins outright.
        pick = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];

        case (state_q)
            IDLE: begin
                if (grant_pend_q) begin
                    // The req_ready cycle is spent idle on the bus; SETUP follows it.
                    grant_pend_d = 1'b0;
                    state_d      = SETUP;
                    psel_d       = 1'b1;
                    penable_d    = 1'b0;
                    wait_cnt_d   = '0;
                end else if (armed_q && (req_valid != 2'b00)) begin
                    // armed_q holds off grants until the second edge after reset release.
                    req_ready_d[pick] = 1'b1;
                    owner_d           = pick;
                    last_grant_d      = pick;
                    grant_pend_d      = 1'b1;
                    paddr_d  = pick ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
                    pwdata_d = pick ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
                    pwrite_d = req_write[pick];
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    // pready wins even on the cycle the wait limit is reached.
                    state_d              = IDLE;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = pwrite ? '0 : prdata;
                    rsp_err_d            = pslverr;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d              = IDLE;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    wait_cnt_d           = wait_cnt_q + 8'd1;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = '0;
                    rsp_err_d            = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclock or negedge presetn) begin
        if (!presetn) begin
            state_q      <= IDLE;
            grant_pend_q <= 1'b0;
            armed_q      <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wait_cnt_q   <= '0;
            req_ready    <= '0;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            paddr        <= '0;
            pwdata       <= '0;
            pwrite       <= 1'b0;
            psel         <= 1'b0;
            penable      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_pend_q <= grant_pend_d;
            armed_q      <= armed_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            req_ready    <= req_ready_d;
            rsp_valid    <= rsp_valid_d;
            rsp_rdata    <= rsp_rdata_d;
            rsp_err      <= rsp_err_d;
            paddr        <= paddr_d;
            pwdata       <= pwdata_d;
            pwrite       <= pwrite_d;
            psel         <= psel_d;
            penable      <= penable_d;
        end
    end

endmodule
